tcnt_apb_rr_master_arb: RTL and testbench

//  Round-robin arbiter/sequencer sharing one APB3/APB4 master port among NUM_REQ

---
 rtl/tcnt_apb_rr_master_arb_if.sv | 42 ++++
 rtl/tcnt_apb_rr_master_arb.sv | 89 ++++++++
 tb/tb_tcnt_apb_rr_master_arb.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcnt_apb_rr_master_arb_if.sv
// tcnt_apb_rr_master_arb_if: client request/response lanes plus the shared APB master port.
// The master modport is the arbiter side, the slave modport is the client/APB-target side.
interface tcnt_apb_rr_master_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  localparam int STRB_W = DATA_W / 8;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ*STRB_W-1:0] req_strb;
  logic [NUM_REQ*3-1:0]      req_prot;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic                      rsp_timeout;
  logic [ADDR_W-1:0]         paddr;
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [2:0]                pprot;
  logic [STRB_W-1:0]         pstrb;
  logic [DATA_W-1:0]         pwdata;
  logic [DATA_W-1:0]         prdata;
  logic                      pready;
  logic                      pslverr;
  modport master (
    input  req_valid, req_addr, req_write, req_wdata, req_strb, req_prot,
    input  prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output paddr, psel, penable, pwrite, pprot, pstrb, pwdata
  );
  modport slave (
    output req_valid, req_addr, req_write, req_wdata, req_strb, req_prot,
    output prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  paddr, psel, penable, pwrite, pprot, pstrb, pwdata
  );
endinterface

// File: rtl/tcnt_apb_rr_master_arb.sv
// tcnt_apb_rr_master_arb: round-robin sharing of one APB master port among NUM_REQ clients,
// one transfer at a time, with registered APB/response outputs and an ACCESS wait timeout.
module tcnt_apb_rr_master_arb #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input logic                      pclk,
  input logic                      prstn,
  tcnt_apb_rr_master_arb_if.master bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 2);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t        state;
  state_t        nxt;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] gnt;
  logic [IW-1:0] owner;
  logic [IW:0]   idx;
  logic [CW-1:0] wcnt;
  logic          any_req;
  logic          grant;
  logic          abort;
  logic          done;
  always_ff @(posedge pclk or negedge prstn)
    if (!prstn) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = grant ? SETUP : (state == SETUP) ? ACCESS : (state == ACCESS && !done) ? ACCESS : IDLE;
  // lowest offset from last_grant wins, so scan offsets from far to near
  always_comb begin
    gnt = last_grant;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = {1'b0, last_grant} + (IW+1)'(k);
      idx = (idx >= (IW+1)'(NUM_REQ)) ? idx - (IW+1)'(NUM_REQ) : idx;
      gnt = bus.req_valid[idx[IW-1:0]] ? idx[IW-1:0] : gnt;
    end
  end
  always_comb begin
    any_req = |bus.req_valid;
    grant = (state == IDLE) && any_req;
    abort = (TIMEOUT != 0) && (state == ACCESS) && (wcnt == CW'(TIMEOUT));
    done = (state == ACCESS) && (abort || bus.pready);
    bus.req_ready = grant ? NUM_REQ'(1) << gnt : '0;
  end
  // counts ACCESS cycles that saw pready=0; the abort cycle itself ignores pready
  always_ff @(posedge pclk or negedge prstn)
    if (!prstn) wcnt <= '0;
    else if (state != ACCESS) wcnt <= '0;
    else if (!bus.pready && !abort) wcnt <= wcnt + 1'b1;
  always_ff @(posedge pclk or negedge prstn)
    if (!prstn) begin
      bus.psel <= 1'b0;
      bus.penable <= 1'b0;
      bus.paddr <= '0;
      bus.pwrite <= 1'b0;
      bus.pwdata <= '0;
      bus.pstrb <= '0;
      bus.pprot <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err <= 1'b0;
      bus.rsp_timeout <= 1'b0;
      last_grant <= IW'(NUM_REQ - 1);
      owner <= '0;
    end else begin
      bus.psel <= nxt != IDLE;
      bus.penable <= nxt == ACCESS;
      bus.rsp_valid <= done ? NUM_REQ'(1) << owner : '0;
      if (grant) begin
        last_grant <= gnt;
        owner <= gnt;
        bus.pwrite <= bus.req_write[gnt];
        bus.paddr <= bus.req_addr[gnt*ADDR_W +: ADDR_W];
        bus.pprot <= bus.req_prot[gnt*3 +: 3];
        bus.pwdata <= bus.req_write[gnt] ? bus.req_wdata[gnt*DATA_W +: DATA_W] : '0;
        bus.pstrb <= bus.req_write[gnt] ? bus.req_strb[gnt*STRB_W +: STRB_W] : '0;
      end
      if (done) begin
        bus.rsp_rdata <= (abort || bus.pwrite) ? '0 : bus.prdata;
        bus.rsp_err <= abort || bus.pslverr;
        bus.rsp_timeout <= abort;
      end
    end
endmodule

// File: tb/tb_tcnt_apb_rr_master_arb.sv
// tb_tcnt_apb_rr_master_arb: directed and randomized checks of the APB round-robin master
// against a transaction-level model of the arbitration and APB phase rules.
module tb_tcnt_apb_rr_master_arb;
  localparam int N = 4, AW = 32, DW = 32, SW = DW / 8, TO = 8;
  logic pclk = 1'b0;
  logic prstn = 1'b0;
  int tests = 0, fails = 0, cyc = 0;
  always #5 pclk = ~pclk;
  tcnt_apb_rr_master_arb_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
  tcnt_apb_rr_master_arb #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .prstn(prstn), .bus(bus));
  bit pend[N];
  logic [AW-1:0] t_addr[N];
  bit t_wr[N];
  logic [DW-1:0] t_wdata[N];
  logic [SW-1:0] t_strb[N];
  logic [2:0] t_prot[N];
  // ph: 0 idle, 1 setup, 2 access (phase the DUT is in during the modelled cycle)
  int ph = 0, own = 0, ptr = N - 1, waits = 0, nwait = 0;
  bit rsp_due = 0, r_err = 0, e_err = 0, e_to = 0;
  logic [DW-1:0] r_data = '0, e_rdata = '0;
  logic [AW-1:0] c_addr = '0;
  bit c_wr = 0;
  logic [DW-1:0] c_wdata = '0;
  logic [SW-1:0] c_strb = '0;
  logic [2:0] c_prot = '0;
  int fix_wait = -1, fix_err = -1;
  bit fix_data_en = 0, auto_req = 0, refill = 0, got_rsp = 0, o_err = 0, o_to = 0;
  logic [DW-1:0] fix_data = '0, o_rdata = '0, seen_or = '0;
  logic [N-1:0] o_vld = '0;
  int glog[$];
  int g_cyc = 0, r_cyc = 0, pen_obs = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] onehot(int i);
    return N'(1) << i;
  endfunction

  function automatic int rr_pick();
    for (int k = 1; k <= N; k++) if (pend[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic new_txn(int i);
    pend[i] = 1;
    t_addr[i] = $urandom;
    t_wr[i] = 1'($urandom);
    t_wdata[i] = $urandom;
    t_strb[i] = SW'($urandom);
    t_prot[i] = 3'($urandom);
  endtask

  task automatic set_txn(int i, bit wr, logic [AW-1:0] a, logic [DW-1:0] d, logic [SW-1:0] s);
    new_txn(i);
    t_wr[i] = wr;
    t_addr[i] = a;
    t_wdata[i] = d;
    t_strb[i] = s;
    t_prot[i] = 3'd0;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = pend[i];
      bus.req_write[i] = t_wr[i];
      bus.req_addr[i*AW +: AW] = t_addr[i];
      bus.req_wdata[i*DW +: DW] = t_wdata[i];
      bus.req_strb[i*SW +: SW] = t_strb[i];
      bus.req_prot[i*3 +: 3] = t_prot[i];
    end
  endtask

  // one clock: check registered outputs, play the APB target, drive clients, check req_ready
  task automatic step();
    bit done;
    int g, ph_n;
    done = 0;
    @(negedge pclk);
    cyc++;
    chk("psel", 64'(bus.psel), 64'(ph != 0));
    chk("penable", 64'(bus.penable), 64'(ph == 2));
    if (ph != 0) begin
      chk("paddr", 64'(bus.paddr), 64'(c_addr));
      chk("pwrite", 64'(bus.pwrite), 64'(c_wr));
      chk("pwdata", 64'(bus.pwdata), 64'(c_wdata));
      chk("pstrb", 64'(bus.pstrb), 64'(c_strb));
      chk("pprot", 64'(bus.pprot), 64'(c_prot));
      seen_or |= bus.pwdata | DW'(bus.pstrb);
    end
    if (bus.penable) pen_obs++;
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(rsp_due ? onehot(own) : {N{1'b0}}));
    chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e_rdata));
    chk("rsp_err", 64'(bus.rsp_err), 64'(e_err));
    chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(e_to));
    if (bus.rsp_valid != 0) begin
      got_rsp = 1;
      r_cyc = cyc;
      o_vld = bus.rsp_valid;
      o_rdata = bus.rsp_rdata;
      o_err = bus.rsp_err;
      o_to = bus.rsp_timeout;
    end
    bus.pready = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata = $urandom;
    if (ph == 1) begin
      waits = 0;
      nwait = (fix_wait >= 0) ? fix_wait : ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
      r_err = (fix_err >= 0) ? fix_err[0] : ($urandom_range(0, 7) == 0);
      r_data = fix_data_en ? fix_data : $urandom;
    end
    if (ph == 2) begin
      if (waits == TO) begin
        bus.pready = 1'($urandom);
        bus.pslverr = 1'($urandom);
        done = 1;
        e_err = 1;
        e_to = 1;
        e_rdata = '0;
      end else if (waits == nwait) begin
        bus.pready = 1'b1;
        bus.pslverr = r_err;
        bus.prdata = r_data;
        done = 1;
        e_err = r_err;
        e_to = 0;
        e_rdata = c_wr ? '0 : r_data;
      end else waits++;
    end
    ph_n = (ph == 1) ? 2 : (ph == 2 && !done) ? 2 : 0;
    if (auto_req) for (int i = 0; i < N; i++) begin
      if (!pend[i] && $urandom_range(0, 2) == 0) new_txn(i);
      else if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 0;
    end
    drive_reqs();
    #1;
    g = (ph == 0) ? rr_pick() : -1;
    chk("req_ready", 64'(bus.req_ready), 64'((g < 0) ? {N{1'b0}} : onehot(g)));
    if (g >= 0) begin
      glog.push_back(g);
      ptr = g;
      own = g;
      ph_n = 1;
      g_cyc = cyc;
      pen_obs = 0;
      seen_or = '0;
      c_addr = t_addr[g];
      c_wr = t_wr[g];
      c_wdata = t_wr[g] ? t_wdata[g] : '0;
      c_strb = t_wr[g] ? t_strb[g] : '0;
      c_prot = t_prot[g];
      pend[g] = 0;
      if (refill) new_txn(g);
    end
    ph = ph_n;
    rsp_due = done;
  endtask

  task automatic wait_rsp(int budget);
    got_rsp = 0;
    for (int i = 0; i < budget && !got_rsp; i++) step();
    chk("rsp_arrived", 64'(got_rsp), 64'd1);
  endtask

  task automatic drain(int budget);
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int i = 0; i < budget && (ph != 0 || rsp_due); i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 0;
      t_addr[i] = '0;
      t_wr[i] = 0;
      t_wdata[i] = '0;
      t_strb[i] = '0;
      t_prot[i] = '0;
    end
    drive_reqs();
    bus.pready = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata = '0;
    repeat (3) @(negedge pclk);
    chk("rst_psel", 64'(bus.psel), 64'd0);
    chk("rst_penable", 64'(bus.penable), 64'd0);
    chk("rst_paddr", 64'(bus.paddr), 64'd0);
    chk("rst_pwdata", 64'(bus.pwdata), 64'd0);
    chk("rst_pstrb", 64'(bus.pstrb), 64'd0);
    chk("rst_pprot", 64'(bus.pprot), 64'd0);
    chk("rst_pwrite", 64'(bus.pwrite), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("rst_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    prstn = 1'b1;
    // single zero-wait write from client 1
    fix_wait = 0;
    fix_err = 0;
    set_txn(1, 1, 32'h40, 32'hA5A5_0001, 4'hF);
    wait_rsp(20);
    chk("wr_latency", 64'(r_cyc - g_cyc), 64'd3);
    chk("wr_owner", 64'(o_vld), 64'h2);
    chk("wr_err", 64'(o_err), 64'd0);
    // read with three wait states; write fields must be blanked on the bus
    fix_wait = 3;
    fix_data_en = 1;
    fix_data = 32'h1234_5678;
    set_txn(2, 0, 32'h80, 32'hDEAD_BEEF, 4'hF);
    wait_rsp(20);
    chk("rd_penable_cycles", 64'(pen_obs), 64'd4);
    chk("rd_rdata", 64'(o_rdata), 64'h1234_5678);
    chk("rd_wdata_strb_zero", 64'(seen_or), 64'd0);
    chk("rd_owner", 64'(o_vld), 64'h4);
    fix_data_en = 0;
    // reset in the middle of ACCESS
    fix_wait = 50;
    set_txn(3, 0, 32'hC0, 32'h0, 4'h0);
    for (int i = 0; i < 20 && ph != 2; i++) step();
    @(posedge pclk);
    #2;
    chk("pre_rst_psel", 64'(bus.psel), 64'd1);
    chk("pre_rst_penable", 64'(bus.penable), 64'd1);
    prstn = 1'b0;
    #1;
    chk("midrst_psel", 64'(bus.psel), 64'd0);
    chk("midrst_penable", 64'(bus.penable), 64'd0);
    repeat (2) begin
      @(negedge pclk);
      chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    end
    ph = 0;
    rsp_due = 0;
    ptr = N - 1;
    e_rdata = '0;
    e_err = 0;
    e_to = 0;
    prstn = 1'b1;
    // all clients continuously requesting: strict rotation from client 0
    fix_wait = 0;
    refill = 1;
    glog.delete();
    for (int i = 0; i < N; i++) new_txn(i);
    for (int i = 0; i < 60 && glog.size() < 5; i++) step();
    chk("rr_grants", 64'(glog.size()), 64'd5);
    for (int i = 0; i < 5 && i < glog.size(); i++) chk("rr_order", 64'(glog[i]), 64'(i % N));
    refill = 0;
    drain(40);
    // slave error on a write
    fix_err = 1;
    set_txn(0, 1, 32'h100, 32'h0BAD_F00D, 4'h3);
    wait_rsp(20);
    chk("slverr_err", 64'(o_err), 64'd1);
    chk("slverr_timeout", 64'(o_to), 64'd0);
    fix_err = 0;
    // pready stuck low: abort after TO waiting cycles, then a normal transfer
    fix_wait = 100;
    set_txn(1, 0, 32'h200, 32'h0, 4'h0);
    wait_rsp(40);
    chk("to_timeout", 64'(o_to), 64'd1);
    chk("to_err", 64'(o_err), 64'd1);
    chk("to_rdata", 64'(o_rdata), 64'd0);
    chk("to_penable_cycles", 64'(pen_obs), 64'(TO + 1));
    fix_wait = 0;
    set_txn(2, 1, 32'h204, 32'h5555_AAAA, 4'hF);
    wait_rsp(20);
    chk("after_to_err", 64'(o_err), 64'd0);
    chk("after_to_timeout", 64'(o_to), 64'd0);
    chk("after_to_owner", 64'(o_vld), 64'h4);
    // randomized traffic, wait states, errors, timeouts and withdrawals
    fix_wait = -1;
    fix_err = -1;
    auto_req = 1;
    repeat (800) step();
    auto_req = 0;
    drain(60);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
